// File: rtl/elevator_call_scheduler_if.sv
// Request/position bundle between the call scheduler and the elevator car.
// The scheduler takes the master view: it drives floor_req and the status
// outputs and observes buttons and car position.
interface elevator_call_scheduler_if #(
  parameter int N_FLOORS = 5
);
  logic [N_FLOORS-1:0] btn;
  logic [N_FLOORS-1:0] floor_pos;
  logic [N_FLOORS-1:0] floor_req;
  logic [N_FLOORS-1:0] pending;
  logic                dir_up;
  logic                busy;
  logic                pos_err;

  modport master (
    input  btn,
    input  floor_pos,
    output floor_req,
    output pending,
    output dir_up,
    output busy,
    output pos_err
  );

  modport slave (
    output btn,
    output floor_pos,
    input  floor_req,
    input  pending,
    input  dir_up,
    input  busy,
    input  pos_err
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN-ordered elevator call scheduler. Latches button presses into a
// pending set, picks one target at a time (keep direction, reverse only when
// nothing is ahead), holds it until the car arrives, dwells, then clears it.
module elevator_call_scheduler #(
  parameter int N_FLOORS     = 5,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  elevator_call_scheduler_if.master  bus
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [N_FLOORS-1:0] ZERO     = {N_FLOORS{1'b0}};
  localparam logic [N_FLOORS-1:0] ONE      = {{(N_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPATCH = 2'd2,
    DWELL    = 2'd3
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [N_FLOORS-1:0] v);
    return (v != ZERO) && ((v & (v - ONE)) == ZERO);
  endfunction

  // Isolates the lowest set bit (nearest call above when applied to an upper mask).
  function automatic logic [N_FLOORS-1:0] lowest_bit(input logic [N_FLOORS-1:0] v);
    return v & (~v + ONE);
  endfunction

  // Isolates the highest set bit (nearest call below when applied to a lower mask).
  function automatic logic [N_FLOORS-1:0] highest_bit(input logic [N_FLOORS-1:0] v);
    logic [N_FLOORS-1:0] r;
    r = ZERO;
    for (int i = 0; i < N_FLOORS; i++) begin
      r = v[i] ? (ONE << i) : r;
    end
    return r;
  endfunction

  state_t              state_r, state_next_s;
  logic [N_FLOORS-1:0] btn_q_r, pending_r, last_floor_r, floor_req_r;
  logic [N_FLOORS-1:0] req_next_s, clr_s, press_s, pending_next_s;
  logic [N_FLOORS-1:0] above_mask_s, below_mask_s, calls_above_s, calls_below_s;
  logic [CW-1:0]       cnt_r, cnt_next_s;
  logic                dir_up_r, dir_next_s, busy_r, pos_err_r;
  logic                pos_ok_s, arrive_s;

  assign pos_ok_s = is_onehot(bus.floor_pos);
  assign arrive_s = pos_ok_s && (bus.floor_pos == floor_req_r);

  // A press at the floor currently being dwelt at is already served.
  assign press_s        = bus.btn & ~btn_q_r & ~((state_r == DWELL) ? floor_req_r : ZERO);
  assign pending_next_s = (pending_r | press_s) & ~clr_s;

  assign calls_above_s = pending_r & above_mask_s;
  assign calls_below_s = pending_r & below_mask_s;

  // Masks of floors strictly above and strictly below the last known floor.
  always_comb begin
    logic seen_lo;
    logic seen_hi;
    seen_lo      = 1'b0;
    seen_hi      = 1'b0;
    above_mask_s = ZERO;
    below_mask_s = ZERO;
    for (int i = 0; i < N_FLOORS; i++) begin
      above_mask_s[i] = seen_lo;
      seen_lo         = seen_lo | last_floor_r[i];
    end
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      below_mask_s[i] = seen_hi;
      seen_hi         = seen_hi | last_floor_r[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, target selection, dwell count and call clearing.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = floor_req_r;
    dir_next_s   = dir_up_r;
    cnt_next_s   = cnt_r;
    clr_s        = ZERO;
    case (state_r)
      IDLE: begin
        req_next_s = ZERO;
        if (pending_r != ZERO) begin
          state_next_s = SELECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SELECT: begin
        state_next_s = DISPATCH;
        if ((pending_r & last_floor_r) != ZERO) begin
          req_next_s = last_floor_r;
        end else if (dir_up_r) begin
          if (calls_above_s != ZERO) begin
            req_next_s = lowest_bit(calls_above_s);
          end else begin
            req_next_s = highest_bit(calls_below_s);
            dir_next_s = 1'b0;
          end
        end else begin
          if (calls_below_s != ZERO) begin
            req_next_s = highest_bit(calls_below_s);
          end else begin
            req_next_s = lowest_bit(calls_above_s);
            dir_next_s = 1'b1;
          end
        end
      end
      DISPATCH: begin
        // Target is frozen for the whole trip; new calls wait for the next SELECT.
        if (arrive_s) begin
          clr_s        = floor_req_r;
          cnt_next_s   = CNT_LOAD;
          state_next_s = DWELL;
        end else begin
          state_next_s = DISPATCH;
        end
      end
      DWELL: begin
        if (cnt_r == CNT_ZERO) begin
          if (pending_r != ZERO) begin
            state_next_s = SELECT;
          end else begin
            state_next_s = IDLE;
            req_next_s   = ZERO;
          end
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        req_next_s   = ZERO;
      end
    endcase
  end

  // Registered datapath and outputs; reset discards all calls and the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q_r      <= ZERO;
      pending_r    <= ZERO;
      last_floor_r <= ONE;
      floor_req_r  <= ZERO;
      dir_up_r     <= 1'b1;
      cnt_r        <= CNT_ZERO;
      busy_r       <= 1'b0;
      pos_err_r    <= 1'b0;
    end else begin
      btn_q_r      <= bus.btn;
      pending_r    <= pending_next_s;
      last_floor_r <= pos_ok_s ? bus.floor_pos : last_floor_r;
      floor_req_r  <= req_next_s;
      dir_up_r     <= dir_next_s;
      cnt_r        <= cnt_next_s;
      busy_r       <= (state_next_s != IDLE);
      pos_err_r    <= ~pos_ok_s;
    end
  end

  assign bus.floor_req = floor_req_r;
  assign bus.pending   = pending_r;
  assign bus.dir_up    = dir_up_r;
  assign bus.busy      = busy_r;
  assign bus.pos_err   = pos_err_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: drives buttons and car position
// through a fixed trip sequence and checks every output against hand-worked values.
module tb_elevator_call_scheduler;
  localparam int N = 5;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  elevator_call_scheduler_if #(.N_FLOORS(N)) bus_if ();

  elevator_call_scheduler #(.N_FLOORS(N), .DWELL_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1;
    bus_if.btn = 5'b00000;
    bus_if.floor_pos = 5'b00001;
    #1 rst = 1'b0;
    #2;
    chk_v("rst_req", bus_if.floor_req, 5'b00000);
    chk_v("rst_pend", bus_if.pending, 5'b00000);
    chk_b("rst_dir", bus_if.dir_up, 1'b1);
    chk_b("rst_busy", bus_if.busy, 1'b0);
    chk_b("rst_poserr", bus_if.pos_err, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);

    // 1: single call at floor 3, latency and dwell length
    bus_if.btn = 5'b00100;
    step(1);
    bus_if.btn = 5'b00000;
    chk_v("t1_pend", bus_if.pending, 5'b00100);
    chk_b("t1_idle", bus_if.busy, 1'b0);
    step(1);
    chk_b("t1_sel_busy", bus_if.busy, 1'b1);
    chk_v("t1_sel_req", bus_if.floor_req, 5'b00000);
    step(1);
    chk_v("t1_req", bus_if.floor_req, 5'b00100);
    chk_b("t1_dir", bus_if.dir_up, 1'b1);
    step(2);
    chk_v("t1_req_hold", bus_if.floor_req, 5'b00100);
    bus_if.floor_pos = 5'b00100;
    step(1);
    chk_v("t1_clr", bus_if.pending, 5'b00000);
    for (int k = 0; k < 4; k++) begin
      chk_v("t1_dwell_req", bus_if.floor_req, 5'b00100);
      step(1);
    end
    chk_v("t1_done_req", bus_if.floor_req, 5'b00000);
    chk_b("t1_done_busy", bus_if.busy, 1'b0);

    // 2: at floor 3 going up, calls at 4 and 1 -> 4 first, then reverse to 1
    bus_if.btn = 5'b01001;
    step(1);
    bus_if.btn = 5'b00000;
    chk_v("t2_pend", bus_if.pending, 5'b01001);
    step(2);
    chk_v("t2_req_up", bus_if.floor_req, 5'b01000);
    chk_b("t2_dir_up", bus_if.dir_up, 1'b1);
    bus_if.floor_pos = 5'b01000;
    step(1);
    chk_v("t2_pend_left", bus_if.pending, 5'b00001);
    step(5);
    chk_v("t2_req_down", bus_if.floor_req, 5'b00001);
    chk_b("t2_dir_down", bus_if.dir_up, 1'b0);
    bus_if.floor_pos = 5'b00001;
    step(5);
    chk_b("t2_idle", bus_if.busy, 1'b0);
    chk_v("t2_pend_none", bus_if.pending, 5'b00000);

    // 3: held button during a trip latches one call and does not retarget
    bus_if.btn = 5'b10000;
    step(1);
    bus_if.btn = 5'b00000;
    step(2);
    chk_v("t3_req", bus_if.floor_req, 5'b10000);
    chk_b("t3_dir", bus_if.dir_up, 1'b1);
    bus_if.btn = 5'b00010;
    step(20);
    bus_if.btn = 5'b00000;
    chk_v("t3_pend_held", bus_if.pending, 5'b10010);
    chk_v("t3_req_kept", bus_if.floor_req, 5'b10000);
    bus_if.floor_pos = 5'b10000;
    step(1);
    chk_v("t3_pend_after", bus_if.pending, 5'b00010);
    step(5);
    chk_v("t3_req_next", bus_if.floor_req, 5'b00010);
    chk_b("t3_dir_next", bus_if.dir_up, 1'b0);
    bus_if.floor_pos = 5'b00010;
    step(5);
    chk_b("t3_idle", bus_if.busy, 1'b0);
    chk_v("t3_pend_none", bus_if.pending, 5'b00000);

    // 4: press absorbed during dwell; press at current floor served with no travel
    bus_if.btn = 5'b01000;
    step(1);
    bus_if.btn = 5'b00000;
    step(2);
    chk_v("t4_req", bus_if.floor_req, 5'b01000);
    bus_if.floor_pos = 5'b01000;
    step(1);
    bus_if.btn = 5'b01000;
    step(1);
    bus_if.btn = 5'b00000;
    chk_v("t4_absorb", bus_if.pending, 5'b00000);
    step(3);
    chk_b("t4_idle", bus_if.busy, 1'b0);
    chk_v("t4_absorb_idle", bus_if.pending, 5'b00000);
    bus_if.btn = 5'b01000;
    step(1);
    bus_if.btn = 5'b00000;
    chk_v("t4_pend_here", bus_if.pending, 5'b01000);
    step(2);
    chk_v("t4_req_here", bus_if.floor_req, 5'b01000);
    chk_v("t4_pend_arrive", bus_if.pending, 5'b01000);
    step(1);
    chk_v("t4_clr_here", bus_if.pending, 5'b00000);
    chk_v("t4_dwell_req", bus_if.floor_req, 5'b01000);
    step(4);
    chk_b("t4_idle2", bus_if.busy, 1'b0);

    // 5: malformed position during a trip
    bus_if.btn = 5'b00001;
    step(1);
    bus_if.btn = 5'b00000;
    step(2);
    chk_v("t5_req", bus_if.floor_req, 5'b00001);
    chk_b("t5_dir", bus_if.dir_up, 1'b0);
    bus_if.floor_pos = 5'b00110;
    chk_b("t5_no_err_yet", bus_if.pos_err, 1'b0);
    step(1);
    bus_if.floor_pos = 5'b01000;
    chk_b("t5_err", bus_if.pos_err, 1'b1);
    chk_b("t5_busy", bus_if.busy, 1'b1);
    step(1);
    chk_b("t5_err_gone", bus_if.pos_err, 1'b0);
    chk_v("t5_no_arrive", bus_if.pending, 5'b00001);
    chk_v("t5_req_kept", bus_if.floor_req, 5'b00001);

    // 6: asynchronous reset mid-trip
    bus_if.btn = 5'b10100;
    step(1);
    bus_if.btn = 5'b00000;
    chk_v("t6_pend", bus_if.pending, 5'b10101);
    chk_b("t6_dir_before", bus_if.dir_up, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_v("t6_rst_req", bus_if.floor_req, 5'b00000);
    chk_v("t6_rst_pend", bus_if.pending, 5'b00000);
    chk_b("t6_rst_busy", bus_if.busy, 1'b0);
    chk_b("t6_rst_dir", bus_if.dir_up, 1'b1);
    step(2);
    rst = 1'b1;
    step(2);
    chk_b("t6_stay_idle", bus_if.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
